// File: rtl/hermes_vc_pkg.sv
// rtl/hermes_vc_pkg.sv - shared types for the Hermes virtual-channel input buffer
package hermes_vc_pkg;

  // Per-VC packet state, one-hot so each output decodes from a single bit
  typedef enum logic [2:0] {
    VC_INIT    = 3'b001,
    VC_REQ     = 3'b010,
    VC_PAYLOAD = 3'b100
  } vc_state_e;

endpackage

// File: rtl/hermes_vc_fifo.sv
// rtl/hermes_vc_fifo.sv - circular FIFO holding one virtual channel's {eop, flit} entries
module hermes_vc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // The extra MSB on each pointer tells full from empty when the low bits match
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers; reset empties the FIFO without touching storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, written at the tail slot
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hermes_vc_buffer.sv
// rtl/hermes_vc_buffer.sv - Hermes input buffer with per-VC FIFOs, packet FSMs and flit-level round-robin output
module hermes_vc_buffer
  import hermes_vc_pkg::*;
#(
  parameter int NUM_VC      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 32,
  localparam int VC_W       = $clog2(NUM_VC)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [VC_W-1:0]      vc_i,
  input  logic                 eop_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [NUM_VC-1:0]    credit_o,
  output logic                 data_av_o,
  output logic [VC_W-1:0]      vc_o,
  output logic                 eop_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 data_ack_i,
  output logic [NUM_VC-1:0]    req_o,
  input  logic [NUM_VC-1:0]    req_ack_i,
  output logic [NUM_VC-1:0]    sending_o
);

  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] eligible;
  logic [FLIT_SIZE:0] head [NUM_VC];
  vc_state_e          state_q [NUM_VC];
  vc_state_e          state_d [NUM_VC];
  logic [VC_W-1:0]    rr_ptr_q;
  logic [VC_W-1:0]    sel;
  logic [VC_W-1:0]    arb_idx;
  logic               found;
  logic               handshake;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign wr_en[g] = rx_i && (vc_i == VC_W'(g)) && !full[g];

    hermes_vc_fifo #(
      .DEPTH (BUFFER_SIZE),
      .WIDTH (FLIT_SIZE + 1)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_i    (wr_en[g]),
      .wdata_i ({eop_i, data_i}),
      .rd_i    (pop[g]),
      .rdata_o (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  assign credit_o = ~full;

  // Per-VC packet state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= VC_INIT;
    end else begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_d[v];
    end
  end

  // Packet lifecycle: wait for a flit, request a route, stream until the eop flit leaves
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      unique case (state_q[v])
        VC_INIT:    if (!empty[v])                        state_d[v] = VC_REQ;
        VC_REQ:     if (req_ack_i[v])                     state_d[v] = VC_PAYLOAD;
        VC_PAYLOAD: if (pop[v] && head[v][FLIT_SIZE])     state_d[v] = VC_INIT;
        default:                                          state_d[v] = VC_INIT;
      endcase
    end
  end

  // Decode per-VC status; a VC in payload with an empty FIFO simply waits
  always_comb begin
    req_o     = '0;
    sending_o = '0;
    eligible  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      req_o[v]     = (state_q[v] == VC_REQ);
      sending_o[v] = (state_q[v] == VC_PAYLOAD);
      eligible[v]  = (state_q[v] == VC_PAYLOAD) && !empty[v];
    end
  end

  // Round-robin pick: first eligible VC at or above rr_ptr, wrapping
  always_comb begin
    sel     = rr_ptr_q;
    found   = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      arb_idx = rr_ptr_q + VC_W'(i);
      if (!found && eligible[arb_idx]) begin
        sel   = arb_idx;
        found = 1'b1;
      end
    end
  end

  assign data_av_o = |eligible;
  assign handshake = data_av_o && data_ack_i;
  assign data_o    = head[sel][FLIT_SIZE-1:0];
  assign eop_o     = head[sel][FLIT_SIZE];
  assign vc_o      = sel;

  // Pop only the selected VC on a handshake
  always_comb begin
    pop = '0;
    for (int v = 0; v < NUM_VC; v++) pop[v] = handshake && (sel == VC_W'(v));
  end

  // Move priority past the VC just served so flits interleave
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        rr_ptr_q <= '0;
    else if (handshake) rr_ptr_q <= sel + 1'b1;
  end

endmodule

// File: tb/tb_hermes_vc_buffer.sv
// tb/tb_hermes_vc_buffer.sv - self-checking bench for hermes_vc_buffer
module tb_hermes_vc_buffer;

  localparam int NV = 2;
  localparam int BS = 8;
  localparam int FW = 32;
  localparam int VW = 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_i = 1'b0;
  logic [VW-1:0] vc_i = '0;
  logic          eop_i = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic [NV-1:0] credit_o;
  logic          data_av_o;
  logic [VW-1:0] vc_o;
  logic          eop_o;
  logic [FW-1:0] data_o;
  logic          data_ack_i = 1'b0;
  logic [NV-1:0] req_o;
  logic [NV-1:0] req_ack_i = '0;
  logic [NV-1:0] sending_o;

  int total = 0;
  int bad = 0;

  // Reference model: flit queues, packet phase per VC (0 idle, 1 routing, 2 streaming), priority pointer
  logic [FW:0] mq [NV][$];
  int          ph [NV];
  int          rr;

  hermes_vc_buffer #(.NUM_VC(NV), .BUFFER_SIZE(BS), .FLIT_SIZE(FW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .vc_i(vc_i), .eop_i(eop_i),
    .data_i(data_i), .credit_o(credit_o), .data_av_o(data_av_o), .vc_o(vc_o),
    .eop_o(eop_o), .data_o(data_o), .data_ack_i(data_ack_i), .req_o(req_o),
    .req_ack_i(req_ack_i), .sending_o(sending_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void m_clear();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      ph[v] = 0;
    end
    rr = 0;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < NV; i++) begin
      int v;
      v = (rr + i) % NV;
      if (ph[v] == 2 && mq[v].size() > 0) return v;
    end
    return -1;
  endfunction

  function automatic logic [NV-1:0] m_credit();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = (mq[v].size() < BS);
    return r;
  endfunction

  function automatic logic [NV-1:0] m_phase(input int p);
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = (ph[v] == p);
    return r;
  endfunction

  function automatic void m_update(input logic rx, input logic [VW-1:0] vc, input logic eop,
                                   input logic [FW-1:0] d, input logic ack, input logic [NV-1:0] rack);
    int          s;
    int          nph [NV];
    bit          wr_ok;
    logic [FW:0] h;
    s = m_sel();
    wr_ok = rx && (mq[int'(vc)].size() < BS);
    for (int v = 0; v < NV; v++) begin
      nph[v] = ph[v];
      if (ph[v] == 0 && mq[v].size() > 0) nph[v] = 1;
      else if (ph[v] == 1 && rack[v]) nph[v] = 2;
    end
    if (s >= 0 && ack) begin
      h = mq[s].pop_front();
      if (h[FW]) nph[s] = 0;
      rr = (s + 1) % NV;
    end
    if (wr_ok) mq[int'(vc)].push_back({eop, d});
    for (int v = 0; v < NV; v++) ph[v] = nph[v];
  endfunction

  task automatic step(input logic rx, input logic [VW-1:0] vc, input logic eop,
                      input logic [FW-1:0] d, input logic ack, input logic [NV-1:0] rack);
    rx_i = rx; vc_i = vc; eop_i = eop; data_i = d; data_ack_i = ack; req_ack_i = rack;
    @(posedge clk_i);
    m_update(rx, vc, eop, d, ack, rack);
    #1;
  endtask

  task automatic do_reset();
    rx_i = 1'b0; data_ack_i = 1'b0; req_ack_i = '0;
    rst_ni = 1'b0;
    m_clear();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    total++; if (credit_o !== 2'b11) begin bad++; $display("FAIL reset_credit got=%b exp=11", credit_o); end
    total++; if (data_av_o !== 1'b0) begin bad++; $display("FAIL reset_data_av got=%b exp=0", data_av_o); end
    total++; if (req_o !== 2'b00) begin bad++; $display("FAIL reset_req got=%b exp=00", req_o); end
    total++; if (sending_o !== 2'b00) begin bad++; $display("FAIL reset_sending got=%b exp=00", sending_o); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] exp_d [3];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'hA, 1'b0, 2'b00);
    total++; if (req_o !== 2'b00) begin bad++; $display("FAIL single_req_early got=%b exp=00", req_o); end
    step(1'b1, 1'b0, 1'b0, 32'hB, 1'b0, 2'b00);
    total++; if (req_o !== 2'b01) begin bad++; $display("FAIL single_req got=%b exp=01", req_o); end
    step(1'b1, 1'b0, 1'b1, 32'hC, 1'b0, 2'b01);
    total++; if (sending_o !== 2'b01) begin bad++; $display("FAIL single_sending got=%b exp=01", sending_o); end
    for (int k = 0; k < 3; k++) begin
      total++; if (data_av_o !== 1'b1) begin bad++; $display("FAIL single_av k=%0d got=%b exp=1", k, data_av_o); end
      total++; if (data_o !== exp_d[k] || eop_o !== (k == 2) || vc_o !== 1'b0) begin
        bad++; $display("FAIL single_flit k=%0d got=%h/%b/%0d exp=%h/%b/0", k, data_o, eop_o, vc_o, exp_d[k], (k == 2));
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    end
    total++; if (sending_o !== 2'b00 || req_o !== 2'b00 || data_av_o !== 1'b0) begin
      bad++; $display("FAIL single_back_to_init got=%b/%b/%b exp=00/00/0", sending_o, req_o, data_av_o);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, (i == 3), 32'h400 + i, 1'b0, 2'b11);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 3), 32'h410 + i, 1'b0, 2'b11);
    total++; if (sending_o !== 2'b11) begin bad++; $display("FAIL inter_sending got=%b exp=11", sending_o); end
    for (int k = 0; k < 8; k++) begin
      logic [FW-1:0] ed;
      ed = (k % 2 == 0) ? 32'h400 + k / 2 : 32'h410 + k / 2;
      total++; if (data_av_o !== 1'b1 || vc_o !== VW'(k % 2) || data_o !== ed) begin
        bad++; $display("FAIL inter_seq k=%0d got av=%b vc=%0d d=%h exp av=1 vc=%0d d=%h", k, data_av_o, vc_o, data_o, k % 2, ed);
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    end
    total++; if (sending_o !== 2'b00 || data_av_o !== 1'b0) begin bad++; $display("FAIL inter_done got=%b/%b exp=00/0", sending_o, data_av_o); end
  endtask

  task automatic test_full();
    int cnt;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h200 + i, 1'b0, 2'b00);
      if (i == 6) begin
        total++; if (credit_o !== 2'b11) begin bad++; $display("FAIL full_credit_7 got=%b exp=11", credit_o); end
      end
      if (i >= 7) begin
        total++; if (credit_o !== 2'b01) begin bad++; $display("FAIL full_credit_w%0d got=%b exp=01", i + 1, credit_o); end
      end
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 2'b10);
    total++; if (data_av_o !== 1'b1 || data_o !== 32'h200) begin bad++; $display("FAIL full_head got=%b/%h exp=1/200", data_av_o, data_o); end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    total++; if (credit_o !== 2'b11) begin bad++; $display("FAIL full_credit_after_pop got=%b exp=11", credit_o); end
    cnt = 1;
    for (int c = 0; c < 12; c++) begin
      if (data_av_o === 1'b1) begin
        total++; if (data_o !== 32'h200 + cnt) begin bad++; $display("FAIL full_order n=%0d got=%h exp=%h", cnt, data_o, 32'h200 + cnt); end
        cnt++;
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    end
    total++; if (cnt != 8) begin bad++; $display("FAIL full_count got=%0d exp=8", cnt); end
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h300 + i, 1'b0, 2'b01);
    for (int j = 0; j < 3; j++) begin
      total++; if (data_av_o !== 1'b1 || data_o !== 32'h300 + j) begin bad++; $display("FAIL simul_head j=%0d got=%b/%h exp=1/%h", j, data_av_o, data_o, 32'h300 + j); end
      step(1'b1, 1'b0, 1'b0, 32'h304 + j, 1'b1, 2'b00);
    end
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (data_av_o === 1'b1) begin
        total++; if (data_o !== 32'h303 + cnt) begin bad++; $display("FAIL simul_order n=%0d got=%h exp=%h", cnt, data_o, 32'h303 + cnt); end
        cnt++;
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    end
    total++; if (cnt != 4) begin bad++; $display("FAIL simul_occupancy got=%0d exp=4", cnt); end
  endtask

  task automatic test_reset_mid_packet();
    int cnt;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h500 + i, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b00);
    total++; if (sending_o !== 2'b10) begin bad++; $display("FAIL mid_sending got=%b exp=10", sending_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (credit_o !== 2'b11 || data_av_o !== 1'b0 || req_o !== 2'b00 || sending_o !== 2'b00) begin
      bad++; $display("FAIL mid_reset got credit=%b av=%b req=%b send=%b exp 11/0/00/00", credit_o, data_av_o, req_o, sending_o);
    end
    m_clear();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h600, 1'b0, 2'b10);
    step(1'b1, 1'b1, 1'b1, 32'h601, 1'b0, 2'b10);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (data_av_o === 1'b1) begin
        total++; if (data_o !== 32'h600 + cnt || vc_o !== 1'b1) begin bad++; $display("FAIL mid_new n=%0d got=%h/%0d exp=%h/1", cnt, data_o, vc_o, 32'h600 + cnt); end
        cnt++;
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 2'b10);
    end
    total++; if (cnt != 2 || sending_o !== 2'b00) begin bad++; $display("FAIL mid_new_done got=%0d/%b exp=2/00", cnt, sending_o); end
  endtask

  task automatic test_blocked_req();
    int cnt;
    int seen_vc1;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 2'b00);
    cnt = 0;
    seen_vc1 = 0;
    for (int c = 0; c < 20; c++) begin
      if (data_av_o === 1'b1) begin
        if (vc_o !== 1'b0) seen_vc1++;
        else cnt++;
      end
      step((c < 5), 1'b0, (c == 4), 32'h700 + c, 1'b1, 2'b01);
    end
    total++; if (seen_vc1 != 0) begin bad++; $display("FAIL blocked_vc1_selected got=%0d exp=0", seen_vc1); end
    total++; if (cnt != 5) begin bad++; $display("FAIL blocked_vc0_flits got=%0d exp=5", cnt); end
    total++; if (req_o !== 2'b10 || sending_o !== 2'b00) begin bad++; $display("FAIL blocked_state got=%b/%b exp=10/00", req_o, sending_o); end
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic rx, eop, ack;
      logic [VW-1:0] vc;
      logic [NV-1:0] rack;
      logic [FW-1:0] d;
      s = m_sel();
      total++; if (credit_o !== m_credit()) begin bad++; $display("FAIL rand_credit cyc=%0d got=%b exp=%b", cyc, credit_o, m_credit()); end
      total++; if (req_o !== m_phase(1)) begin bad++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", cyc, req_o, m_phase(1)); end
      total++; if (sending_o !== m_phase(2)) begin bad++; $display("FAIL rand_sending cyc=%0d got=%b exp=%b", cyc, sending_o, m_phase(2)); end
      total++; if (data_av_o !== (s >= 0)) begin bad++; $display("FAIL rand_av cyc=%0d got=%b exp=%b", cyc, data_av_o, (s >= 0)); end
      if (s >= 0) begin
        total++; if (vc_o !== VW'(s) || {eop_o, data_o} !== mq[s][0]) begin
          bad++; $display("FAIL rand_flit cyc=%0d got vc=%0d %b/%h exp vc=%0d %h", cyc, vc_o, eop_o, data_o, s, mq[s][0]);
        end
      end
      rx   = ($urandom_range(0, 99) < 60);
      vc   = VW'($urandom_range(0, NV - 1));
      eop  = ($urandom_range(0, 3) == 0);
      d    = $urandom;
      ack  = ($urandom_range(0, 99) < ((cyc % 300 < 150) ? 20 : 75));
      rack = NV'($urandom_range(0, (1 << NV) - 1));
      step(rx, vc, eop, d, ack, rack);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_interleave();
    test_full();
    test_simultaneous();
    test_reset_mid_packet();
    test_blocked_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
